// File: rtl/Definitions.sv
// Core-wide widths shared by the processor and its surrounding control blocks.
package Definitions;

  // Width of the core's program counter / jump-target path.
  localparam int pgmCtrW = 8;

endpackage

// File: rtl/launcher_pkg.sv
// Types and constants for the program launcher: FSM state encoding and the
// per-program start-address table.
package launcher_pkg;

  import Definitions::*;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    RUN,
    RETIRE
  } launch_state_t;

  // Capacity of the start-address table; NUM_PGMS must not exceed it.
  localparam int MAX_PGMS   = 8;
  localparam int BASE_IDX_W = $clog2(MAX_PGMS);

  // Start address of each program in instruction memory.
  localparam logic [pgmCtrW-1:0] PGM_BASE [MAX_PGMS] = '{
    pgmCtrW'('h10), pgmCtrW'('h3C), pgmCtrW'('h7A), pgmCtrW'('h95),
    pgmCtrW'('hA8), pgmCtrW'('hC3), pgmCtrW'('hD6), pgmCtrW'('hF0)
  };

  // Table lookup with an index already sized to the table.
  function automatic logic [pgmCtrW-1:0] pgm_base(input logic [BASE_IDX_W-1:0] idx);
    return PGM_BASE[idx];
  endfunction

endpackage

// File: rtl/cyc_counter.sv
// Per-program execution-cycle counter: synchronous clear, enable, saturating
// count. With LAUNCH_TIMEOUT_EN defined it also flags when the count reaches
// the watchdog limit.
module cyc_counter #(
  parameter int CYC_W = 16
`ifdef LAUNCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16'hFFFF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CYC_W-1:0] count_nxt_o
`ifdef LAUNCH_TIMEOUT_EN
  , output logic           hit_o
`endif
);

  logic [CYC_W-1:0] count_q;

  // Value the counter takes if this cycle is counted; sticks at all-ones.
  assign count_nxt_o = (count_q == '1) ? count_q : count_q + 1'b1;

`ifdef LAUNCH_TIMEOUT_EN
  localparam logic [CYC_W-1:0] LIMIT = CYC_W'(TIMEOUT);
  // Watchdog fires in the cycle whose count would reach the limit.
  assign hit_o = en_i && (count_nxt_o == LIMIT);
`endif

  // Count register: clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_nxt_o;
    end
  end

endmodule

// File: rtl/prog_launcher.sv
// Run controller: sequences NUM_PGMS programs through the core's init/bgn/jmp
// controls, measures each program's cycle count and reports completion.
// Optional watchdog enabled by defining LAUNCH_TIMEOUT_EN.
module prog_launcher
  import Definitions::*;
  import launcher_pkg::*;
#(
  parameter  int          NUM_PGMS = 3,
  parameter  int          INIT_CYC = 2,
  parameter  int          CYC_W    = 16,
  parameter  int unsigned TIMEOUT  = 16'hFFFF,
  localparam int          IDX_W    = (NUM_PGMS > 1) ? $clog2(NUM_PGMS) : 1
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               start,
  input  logic               core_ack,
  output logic               core_init,
  output logic               core_bgn,
  output logic               core_jmp,
  output logic [pgmCtrW-1:0] start_pc,
  output logic [IDX_W-1:0]   pgm_idx,
  output logic               pgm_done,
  output logic [CYC_W-1:0]   cycles,
  output logic               run_done,
  output logic               timed_out
);

  localparam int                INIT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PGMS - 1);

  // Reject configurations the address table or timing cannot support.
  if (NUM_PGMS < 1 || NUM_PGMS > MAX_PGMS) begin : g_bad_num_pgms
    $error("prog_launcher: NUM_PGMS out of range");
  end
  if (INIT_CYC < 1) begin : g_bad_init_cyc
    $error("prog_launcher: INIT_CYC must be at least 1");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("prog_launcher: TIMEOUT must be at least 1");
  end

  launch_state_t      state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]   pgm_idx_q, pgm_idx_d;
  logic [pgmCtrW-1:0] start_pc_q, start_pc_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               run_done_q, run_done_d;
  logic [CYC_W-1:0]   cnt_nxt;
  logic               cnt_clr, cnt_en;
  logic               timeout_hit;
  logic               run_end;

  cyc_counter #(
    .CYC_W       (CYC_W)
`ifdef LAUNCH_TIMEOUT_EN
    , .TIMEOUT   (TIMEOUT)
`endif
  ) u_cyc_counter (
    .clk         (clk),
    .rst_n       (init_n),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .count_nxt_o (cnt_nxt)
`ifdef LAUNCH_TIMEOUT_EN
    , .hit_o     (timeout_hit)
`endif
  );

`ifndef LAUNCH_TIMEOUT_EN
  assign timeout_hit = 1'b0;
`endif

  // A program ends on the core's acknowledge or, if enabled, the watchdog.
  assign run_end = core_ack || timeout_hit;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    if (init_cnt_q == INIT_LAST) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (run_end) state_d = RETIRE;
      RETIRE:  state_d = (pgm_idx_q == LAST_IDX) ? IDLE : INIT;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    core_init = (state_q == INIT);
    core_jmp  = (state_q == LOAD);
    core_bgn  = (state_q != LOAD) && (state_q != RUN);
    pgm_done  = (state_q == RETIRE);
    cnt_clr   = (state_q == LOAD);
    cnt_en    = (state_q == RUN);
  end

  // Datapath next-state: init timer, program index, start address, results.
  // Results are captured on the RUN->RETIRE edge so they are visible together
  // with the pgm_done pulse.
  always_comb begin
    init_cnt_d = '0;
    pgm_idx_d  = pgm_idx_q;
    start_pc_d = start_pc_q;
    cycles_d   = cycles_q;
    run_done_d = run_done_q;
    if (state_q == INIT && init_cnt_q != INIT_LAST) init_cnt_d = init_cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pgm_idx_d  = '0;
          run_done_d = 1'b0;
        end
      end
      INIT: begin
        if (init_cnt_q == INIT_LAST) start_pc_d = pgm_base(BASE_IDX_W'(pgm_idx_q));
      end
      RUN: begin
        if (run_end) begin
          cycles_d = cnt_nxt;
          if (pgm_idx_q == LAST_IDX) run_done_d = 1'b1;
        end
      end
      RETIRE: begin
        if (pgm_idx_q != LAST_IDX) pgm_idx_d = pgm_idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      init_cnt_q <= '0;
      pgm_idx_q  <= '0;
      start_pc_q <= '0;
      cycles_q   <= '0;
      run_done_q <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      pgm_idx_q  <= pgm_idx_d;
      start_pc_q <= start_pc_d;
      cycles_q   <= cycles_d;
      run_done_q <= run_done_d;
    end
  end

`ifdef LAUNCH_TIMEOUT_EN
  logic timed_out_q;

  // Sticky watchdog flag, cleared only by a new start.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)                        timed_out_q <= 1'b0;
    else if (state_q == IDLE && start)  timed_out_q <= 1'b0;
    else if (state_q == RUN && timeout_hit) timed_out_q <= 1'b1;
  end

  assign timed_out = timed_out_q;
`else
  assign timed_out = 1'b0;
`endif

  assign start_pc = start_pc_q;
  assign pgm_idx  = pgm_idx_q;
  assign cycles   = cycles_q;
  assign run_done = run_done_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: directed runs, core_ack filtering,
// mid-run reset, optional watchdog, and randomized per-program run lengths
// checked against a run-level model (table of start addresses + ack delays).
module tb_prog_launcher;

  import Definitions::*;

  localparam int NUM_PGMS = 3;
  localparam int INIT_CYC = 2;
  localparam int CYC_W    = 16;
  localparam int TIMEOUT  = 50;

  logic               clk = 1'b0;
  logic               init_n = 1'b0;
  logic               start = 1'b0;
  logic               core_ack = 1'b0;
  logic               core_init, core_bgn, core_jmp;
  logic [pgmCtrW-1:0] start_pc;
  logic [1:0]         pgm_idx;
  logic               pgm_done;
  logic [CYC_W-1:0]   cycles;
  logic               run_done, timed_out;

  int checks   = 0;
  int failures = 0;

  // Expected start addresses of programs 0..2.
  logic [pgmCtrW-1:0] exp_base [NUM_PGMS] = '{8'h10, 8'h3C, 8'h7A};

  always #5 clk = ~clk;

  prog_launcher #(
    .NUM_PGMS (NUM_PGMS),
    .INIT_CYC (INIT_CYC),
    .CYC_W    (CYC_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .start     (start),
    .core_ack  (core_ack),
    .core_init (core_init),
    .core_bgn  (core_bgn),
    .core_jmp  (core_jmp),
    .start_pc  (start_pc),
    .pgm_idx   (pgm_idx),
    .pgm_done  (pgm_done),
    .cycles    (cycles),
    .run_done  (run_done),
    .timed_out (timed_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete run. d[p] is the RUN cycle in which core_ack is raised for
  // program p (1 = first RUN cycle); 0 means never ack (watchdog expected).
  // early holds core_ack high through INIT and LOAD, where it must be ignored.
  task automatic do_run(input int d0, input int d1, input int d2, input bit early);
    int d [NUM_PGMS];
    int n_init, budget, exp_cyc;
    bit exp_to;
    d = '{d0, d1, d2};
    exp_to = 1'b0;
    check("idle_bgn", core_bgn, 1);
    check("idle_jmp", core_jmp, 0);
    start    = 1'b1;
    core_ack = early;
    tick();
    start = 1'b0;
    check("start_run_done_clr", run_done, 0);
    check("start_timed_out_clr", timed_out, 0);
    check("start_idx", pgm_idx, 0);
    for (int p = 0; p < NUM_PGMS; p++) begin
      n_init = 0;
      budget = 0;
      while (core_jmp !== 1'b1 && budget < 20) begin
        if (core_init === 1'b1) n_init++;
        budget++;
        tick();
      end
      check($sformatf("p%0d_jmp_seen", p), core_jmp, 1);
      check($sformatf("p%0d_jmp_latency", p), budget, INIT_CYC);
      check($sformatf("p%0d_init_len", p), n_init, INIT_CYC);
      check($sformatf("p%0d_start_pc", p), start_pc, exp_base[p]);
      check($sformatf("p%0d_idx", p), pgm_idx, p);
      check($sformatf("p%0d_load_bgn", p), core_bgn, 0);
      core_ack = 1'b0;
      tick();
      if (d[p] > 0) begin
        repeat (d[p] - 1) tick();
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        exp_cyc = d[p];
      end else begin
        budget = 0;
        while (pgm_done !== 1'b1 && budget < 100) begin
          budget++;
          tick();
        end
        exp_cyc = TIMEOUT;
        exp_to  = 1'b1;
      end
      check($sformatf("p%0d_done", p), pgm_done, 1);
      check($sformatf("p%0d_cycles", p), cycles, exp_cyc);
      check($sformatf("p%0d_run_done", p), run_done, (p == NUM_PGMS - 1));
      check($sformatf("p%0d_timed_out", p), timed_out, exp_to);
      check($sformatf("p%0d_pc_stable", p), start_pc, exp_base[p]);
      check($sformatf("p%0d_retire_bgn", p), core_bgn, 1);
      tick();
      check($sformatf("p%0d_done_pulse", p), pgm_done, 0);
      check($sformatf("p%0d_cycles_hold", p), cycles, exp_cyc);
      if (p < NUM_PGMS - 1) begin
        check($sformatf("p%0d_next_init", p), core_init, 1);
        core_ack = early;
      end else begin
        check("end_run_done", run_done, 1);
        check("end_idle_init", core_init, 0);
        check("end_idle_bgn", core_bgn, 1);
      end
    end
  endtask

  initial begin
    int budget;
    bit saw_done;

    // Reset state.
    init_n = 1'b0;
    #23;
    check("rst_bgn", core_bgn, 1);
    check("rst_init", core_init, 0);
    check("rst_jmp", core_jmp, 0);
    check("rst_pc", start_pc, 0);
    check("rst_idx", pgm_idx, 0);
    check("rst_done", pgm_done, 0);
    check("rst_cycles", cycles, 0);
    check("rst_run_done", run_done, 0);
    check("rst_timed_out", timed_out, 0);
    init_n = 1'b1;
    tick();
    tick();
    check("post_rst_bgn", core_bgn, 1);
    check("post_rst_init", core_init, 0);

    // Directed run with ack 10/20/30 cycles after each jump.
    do_run(10, 20, 30, 1'b0);
    // Ack held in INIT/LOAD is ignored; ack in first RUN cycle gives 1.
    do_run(1, 1, 2, 1'b1);

    // Mid-run reset during program 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 0;
    while (core_jmp !== 1'b1 && budget < 20) begin budget++; tick(); end
    tick();
    repeat (4) tick();
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    check("abort_p0_done", pgm_done, 1);
    tick();
    budget = 0;
    while (core_jmp !== 1'b1 && budget < 20) begin budget++; tick(); end
    check("abort_p1_idx", pgm_idx, 1);
    tick();
    tick();
    #2;
    init_n = 1'b0;
    #1;
    check("abort_bgn", core_bgn, 1);
    check("abort_idx", pgm_idx, 0);
    check("abort_done", pgm_done, 0);
    check("abort_jmp", core_jmp, 0);
    init_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pgm_done !== 1'b0 || core_init !== 1'b0) saw_done = 1'b1;
    end
    check("abort_stays_idle", saw_done, 0);

`ifdef LAUNCH_TIMEOUT_EN
    // Program 0 never acknowledged: watchdog retires it, run continues.
    do_run(0, 7, 3, 1'b0);
`endif

    // Randomized run lengths and ack-early behaviour.
    for (int r = 0; r < 4; r++) begin
      int ra, rb, rc;
      bit re;
      ra = int'($urandom_range(1, 40));
      rb = int'($urandom_range(1, 40));
      rc = int'($urandom_range(1, 40));
      re = 1'($urandom_range(0, 1));
      do_run(ra, rb, rc, re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
